axi_burst_shim: RTL and testbench

//  Parametrised AXI4 master adapter between cache/MMU request ports and the ariane AXI bus. Successor shim:

---
 rtl/axi_burst_shim_if.sv | 71 +++++++
 rtl/axi_burst_shim.sv | 198 +++++++++++++++++++
 tb/tb_axi_burst_shim.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi_burst_shim_if.sv
// rtl/axi_burst_shim_if.sv - AXI4 bus seen by the burst shim (AW/W/B/AR/R channels)
interface axi_burst_shim_if #(
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned AxiUserWidth = 64,
  parameter int unsigned AxiIdWidth   = 4
) ();
  logic                      aw_valid, aw_ready, aw_lock;
  logic [AxiAddrWidth-1:0]   aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size, aw_prot;
  logic [1:0]                aw_burst;
  logic [3:0]                aw_cache, aw_qos, aw_region;
  logic [5:0]                aw_atop;
  logic [AxiIdWidth-1:0]     aw_id;
  logic [AxiUserWidth-1:0]   aw_user;

  logic                      w_valid, w_ready, w_last;
  logic [AxiDataWidth-1:0]   w_data;
  logic [AxiDataWidth/8-1:0] w_strb;
  logic [AxiUserWidth-1:0]   w_user;

  logic                      b_valid, b_ready;
  logic [AxiIdWidth-1:0]     b_id;
  logic [1:0]                b_resp;

  logic                      ar_valid, ar_ready, ar_lock;
  logic [AxiAddrWidth-1:0]   ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size, ar_prot;
  logic [1:0]                ar_burst;
  logic [3:0]                ar_cache, ar_qos, ar_region;
  logic [AxiIdWidth-1:0]     ar_id;
  logic [AxiUserWidth-1:0]   ar_user;

  logic                      r_valid, r_ready, r_last;
  logic [AxiDataWidth-1:0]   r_data;
  logic [AxiUserWidth-1:0]   r_user;
  logic [AxiIdWidth-1:0]     r_id;
  logic [1:0]                r_resp;

  modport master (
    output aw_valid, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_id, aw_user,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_user, w_last,
    input  w_ready,
    input  b_valid, b_id, b_resp,
    output b_ready,
    output ar_valid, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_id, ar_user,
    input  ar_ready,
    input  r_valid, r_data, r_user, r_id, r_resp, r_last,
    output r_ready
  );

  modport slave (
    input  aw_valid, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_id, aw_user,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_user, w_last,
    output w_ready,
    output b_valid, b_id, b_resp,
    input  b_ready,
    input  ar_valid, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_id, ar_user,
    output ar_ready,
    output r_valid, r_data, r_user, r_id, r_resp, r_last,
    input  r_ready
  );
endinterface

// File: rtl/axi_burst_shim.sv
// rtl/axi_burst_shim.sv - AXI4 master adapter with decoupled AW/W and bounded outstanding reads/writes
module axi_burst_shim #(
  parameter int unsigned AxiAddrWidth     = 64,
  parameter int unsigned AxiDataWidth     = 64,
  parameter int unsigned AxiUserWidth     = 64,
  parameter int unsigned AxiIdWidth       = 4,
  parameter int unsigned AxiNumWords      = 4,
  parameter int unsigned MaxOutstandingWr = 4,
  parameter int unsigned MaxOutstandingRd = 4,
  localparam int unsigned BlenW  = (AxiNumWords > 1) ? $clog2(AxiNumWords) : 1,
  localparam int unsigned WrCntW = $clog2(MaxOutstandingWr + 1),
  localparam int unsigned RdCntW = $clog2(MaxOutstandingRd + 1)
) (
  input  logic                                           clk_i,
  input  logic                                           rst_ni,
  input  logic                                           rd_req_i,
  output logic                                           rd_gnt_o,
  input  logic [AxiAddrWidth-1:0]                        rd_addr_i,
  input  logic [BlenW-1:0]                               rd_blen_i,
  input  logic [2:0]                                     rd_size_i,
  input  logic [AxiIdWidth-1:0]                          rd_id_i,
  input  logic                                           rd_lock_i,
  input  logic                                           rd_rdy_i,
  output logic                                           rd_valid_o,
  output logic                                           rd_last_o,
  output logic [AxiDataWidth-1:0]                        rd_data_o,
  output logic [AxiUserWidth-1:0]                        rd_user_o,
  output logic [AxiIdWidth-1:0]                          rd_id_o,
  output logic                                           rd_exokay_o,
  input  logic                                           wr_req_i,
  output logic                                           wr_gnt_o,
  input  logic [AxiAddrWidth-1:0]                        wr_addr_i,
  input  logic [BlenW-1:0]                               wr_blen_i,
  input  logic [2:0]                                     wr_size_i,
  input  logic [AxiIdWidth-1:0]                          wr_id_i,
  input  logic                                           wr_lock_i,
  input  logic [5:0]                                     wr_atop_i,
  input  logic [AxiNumWords-1:0][AxiDataWidth-1:0]       wr_data_i,
  input  logic [AxiNumWords-1:0][AxiUserWidth-1:0]       wr_user_i,
  input  logic [AxiNumWords-1:0][AxiDataWidth/8-1:0]     wr_be_i,
  input  logic                                           wr_rdy_i,
  output logic                                           wr_valid_o,
  output logic [AxiIdWidth-1:0]                          wr_id_o,
  output logic                                           wr_exokay_o,
  output logic [WrCntW-1:0]                              wr_outstanding_o,
  output logic [RdCntW-1:0]                              rd_outstanding_o,
  axi_burst_shim_if.master                               axi
);
  localparam logic [WrCntW-1:0] MaxWr     = WrCntW'(MaxOutstandingWr);
  localparam logic [RdCntW-1:0] MaxRd     = RdCntW'(MaxOutstandingRd);
  localparam logic [1:0]        BurstIncr = 2'b01;
  localparam logic [1:0]        RespExOk  = 2'b01;

  typedef enum logic [1:0] {WR_IDLE, WR_BOTH, WR_DATA, WR_ADDR} wr_state_e;

  wr_state_e          state_q, state_d;
  logic [BlenW-1:0]   wcnt_q, wcnt_d;
  logic [WrCntW-1:0]  wr_cnt_q, wr_cnt_d;
  logic [RdCntW-1:0]  rd_cnt_q, rd_cnt_d;
  logic               aw_valid, w_valid, w_last, wr_gnt, wr_room, ar_valid, rd_gnt;
  int                 wr_next, rd_next;

  // An atomic that returns R data also occupies a read slot.
  assign wr_room = (wr_cnt_q < MaxWr) && (!wr_atop_i[5] || (rd_cnt_q < MaxRd));
  assign w_last  = (wcnt_q == wr_blen_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= WR_IDLE;
      wcnt_q   <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    aw_valid = 1'b0;
    w_valid  = 1'b0;
    wr_gnt   = 1'b0;
    case (state_q)
      WR_IDLE, WR_BOTH: begin
        // Once WR_BOTH is entered the request is committed, so no throttle re-check.
        if ((state_q == WR_BOTH) || (wr_req_i && wr_room)) begin
          aw_valid = 1'b1;
          w_valid  = 1'b1;
          if (axi.aw_ready && axi.w_ready && w_last) begin
            wr_gnt  = 1'b1;
            wcnt_d  = '0;
            state_d = WR_IDLE;
          end else if (axi.aw_ready) begin
            state_d = WR_DATA;
            if (axi.w_ready) wcnt_d = wcnt_q + 1'b1;
          end else if (axi.w_ready) begin
            if (w_last) begin
              state_d = WR_ADDR;
            end else begin
              state_d = WR_BOTH;
              wcnt_d  = wcnt_q + 1'b1;
            end
          end
        end
      end
      WR_DATA: begin
        w_valid = 1'b1;
        if (axi.w_ready) begin
          if (w_last) begin
            wr_gnt  = 1'b1;
            wcnt_d  = '0;
            state_d = WR_IDLE;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      WR_ADDR: begin
        aw_valid = 1'b1;
        if (axi.aw_ready) begin
          wr_gnt  = 1'b1;
          wcnt_d  = '0;
          state_d = WR_IDLE;
        end
      end
      default: state_d = WR_IDLE;
    endcase
  end

  assign ar_valid = rd_req_i && (rd_cnt_q < MaxRd);
  assign rd_gnt   = ar_valid && axi.ar_ready;

  // A plain read and an atomic may be granted together; the read count saturates at its bound.
  always_comb begin
    wr_next = int'(wr_cnt_q) + (wr_gnt ? 1 : 0)
            - ((axi.b_valid && wr_rdy_i && (wr_cnt_q != '0)) ? 1 : 0);
    rd_next = int'(rd_cnt_q) + (rd_gnt ? 1 : 0) + ((wr_gnt && wr_atop_i[5]) ? 1 : 0)
            - ((axi.r_valid && rd_rdy_i && axi.r_last && (rd_cnt_q != '0)) ? 1 : 0);
    if (rd_next > int'(MaxOutstandingRd)) rd_next = int'(MaxOutstandingRd);
    wr_cnt_d = WrCntW'(wr_next);
    rd_cnt_d = RdCntW'(rd_next);
  end

  assign axi.aw_valid  = aw_valid;
  assign axi.aw_addr   = wr_addr_i;
  assign axi.aw_len    = 8'(wr_blen_i);
  assign axi.aw_size   = wr_size_i;
  assign axi.aw_burst  = BurstIncr;
  assign axi.aw_lock   = wr_lock_i;
  assign axi.aw_cache  = 4'b0010;
  assign axi.aw_prot   = '0;
  assign axi.aw_qos    = '0;
  assign axi.aw_region = '0;
  assign axi.aw_atop   = wr_atop_i;
  assign axi.aw_id     = wr_id_i;
  assign axi.aw_user   = '0;

  assign axi.w_valid   = w_valid;
  assign axi.w_data    = wr_data_i[wcnt_q];
  assign axi.w_strb    = wr_be_i[wcnt_q];
  assign axi.w_user    = wr_user_i[wcnt_q];
  assign axi.w_last    = w_last;

  assign axi.b_ready   = wr_rdy_i;
  assign wr_valid_o    = axi.b_valid;
  assign wr_id_o       = axi.b_id;
  assign wr_exokay_o   = (axi.b_resp == RespExOk);

  assign axi.ar_valid  = ar_valid;
  assign axi.ar_addr   = rd_addr_i;
  assign axi.ar_len    = 8'(rd_blen_i);
  assign axi.ar_size   = rd_size_i;
  assign axi.ar_burst  = BurstIncr;
  assign axi.ar_lock   = rd_lock_i;
  assign axi.ar_cache  = 4'b0010;
  assign axi.ar_prot   = '0;
  assign axi.ar_qos    = '0;
  assign axi.ar_region = '0;
  assign axi.ar_id     = rd_id_i;
  assign axi.ar_user   = '0;

  assign axi.r_ready   = rd_rdy_i;
  assign rd_valid_o    = axi.r_valid;
  assign rd_last_o     = axi.r_last;
  assign rd_data_o     = axi.r_data;
  assign rd_user_o     = axi.r_user;
  assign rd_id_o       = axi.r_id;
  assign rd_exokay_o   = (axi.r_resp == RespExOk);

  assign rd_gnt_o         = rd_gnt;
  assign wr_gnt_o         = wr_gnt;
  assign wr_outstanding_o = wr_cnt_q;
  assign rd_outstanding_o = rd_cnt_q;
endmodule

// File: tb/tb_axi_burst_shim.sv
// tb/tb_axi_burst_shim.sv - directed bench for axi_burst_shim (write bursts, throttling, reads, reset, atomics)
module tb_axi_burst_shim;
  localparam int AW = 32, DW = 32, UW = 4, IW = 4, NW = 4;

  logic clk, rst_n;
  logic rd_req, rd_gnt, rd_lock, rd_rdy, rd_valid, rd_last, rd_exokay;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [1:0] rd_blen, wr_blen;
  logic [2:0] rd_size, wr_size;
  logic [IW-1:0] rd_id, rd_id_o, wr_id, wr_id_o;
  logic [DW-1:0] rd_data;
  logic [UW-1:0] rd_user;
  logic wr_req, wr_gnt, wr_lock, wr_rdy, wr_valid, wr_exokay;
  logic [5:0] wr_atop;
  logic [NW-1:0][DW-1:0] wr_data;
  logic [NW-1:0][UW-1:0] wr_user;
  logic [NW-1:0][DW/8-1:0] wr_be;
  logic [1:0] wr_out;
  logic [0:0] rd_out;
  int n_tests, n_fail, aw_hs;

  axi_burst_shim_if #(.AxiAddrWidth(AW), .AxiDataWidth(DW), .AxiUserWidth(UW), .AxiIdWidth(IW)) axi ();

  axi_burst_shim #(
    .AxiAddrWidth(AW), .AxiDataWidth(DW), .AxiUserWidth(UW), .AxiIdWidth(IW),
    .AxiNumWords(NW), .MaxOutstandingWr(2), .MaxOutstandingRd(1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .rd_req_i(rd_req), .rd_gnt_o(rd_gnt), .rd_addr_i(rd_addr), .rd_blen_i(rd_blen),
    .rd_size_i(rd_size), .rd_id_i(rd_id), .rd_lock_i(rd_lock), .rd_rdy_i(rd_rdy),
    .rd_valid_o(rd_valid), .rd_last_o(rd_last), .rd_data_o(rd_data), .rd_user_o(rd_user),
    .rd_id_o(rd_id_o), .rd_exokay_o(rd_exokay),
    .wr_req_i(wr_req), .wr_gnt_o(wr_gnt), .wr_addr_i(wr_addr), .wr_blen_i(wr_blen),
    .wr_size_i(wr_size), .wr_id_i(wr_id), .wr_lock_i(wr_lock), .wr_atop_i(wr_atop),
    .wr_data_i(wr_data), .wr_user_i(wr_user), .wr_be_i(wr_be), .wr_rdy_i(wr_rdy),
    .wr_valid_o(wr_valid), .wr_id_o(wr_id_o), .wr_exokay_o(wr_exokay),
    .wr_outstanding_o(wr_out), .rd_outstanding_o(rd_out),
    .axi(axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; aw_hs = 0;
    rst_n = 1'b0;
    rd_req = 0; rd_addr = 32'h2000; rd_blen = 2'd1; rd_size = 3'd2; rd_id = 4'd5; rd_lock = 0; rd_rdy = 0;
    wr_req = 0; wr_addr = 32'h1000; wr_blen = 2'd0; wr_size = 3'd2; wr_id = 4'd3; wr_lock = 0;
    wr_atop = 6'h00; wr_rdy = 0;
    for (int k = 0; k < NW; k++) begin
      wr_data[k] = 32'hA0 + k;
      wr_user[k] = UW'(k);
      wr_be[k]   = 4'hF;
    end
    axi.aw_ready = 0; axi.w_ready = 0; axi.ar_ready = 0;
    axi.b_valid = 0; axi.b_id = '0; axi.b_resp = 2'b00;
    axi.r_valid = 0; axi.r_last = 0; axi.r_data = '0; axi.r_user = '0; axi.r_id = '0; axi.r_resp = 2'b00;

    // reset state
    nxt(); nxt(); #1;
    chk("rst_aw_valid", axi.aw_valid, 0);
    chk("rst_w_valid", axi.w_valid, 0);
    chk("rst_wr_out", wr_out, 0);
    chk("rst_rd_out", rd_out, 0);
    nxt(); rst_n = 1'b1;

    // T1: single beat, both ready -> same-cycle grant
    nxt(); wr_req = 1; wr_blen = 0; axi.aw_ready = 1; axi.w_ready = 1; #1;
    chk("t1_aw_valid", axi.aw_valid, 1);
    chk("t1_w_last", axi.w_last, 1);
    chk("t1_w_data", axi.w_data, 32'hA0);
    chk("t1_gnt", wr_gnt, 1);
    chk("t1_aw_len", axi.aw_len, 0);
    chk("t1_aw_burst", axi.aw_burst, 2'b01);
    chk("t1_aw_cache", axi.aw_cache, 4'b0010);
    chk("t1_wr_out_pre", wr_out, 0);
    nxt(); wr_req = 0; #1;
    chk("t1_wr_out_post", wr_out, 1);
    chk("t1_aw_idle", axi.aw_valid, 0);
    nxt(); axi.b_valid = 1; axi.b_id = 4'd3; axi.b_resp = 2'b01; wr_rdy = 1; #1;
    chk("t1_b_valid", wr_valid, 1);
    chk("t1_b_id", wr_id_o, 3);
    chk("t1_b_exokay", wr_exokay, 1);
    chk("t1_b_ready", axi.b_ready, 1);
    nxt(); axi.b_valid = 0; wr_rdy = 0; #1;
    chk("t1_wr_out_b", wr_out, 0);

    // T2: 4-beat burst, AW stalled 6 cycles -> W completes first, WR_ADDR
    for (int i = 0; i < 7; i++) begin
      nxt(); wr_req = 1; wr_blen = 3; axi.aw_ready = (i == 6); axi.w_ready = 1; #1;
      chk("t2_aw_valid", axi.aw_valid, 1);
      chk("t2_w_valid", axi.w_valid, (i < 4));
      if (i < 4) begin
        chk("t2_w_data", axi.w_data, 32'hA0 + i);
        chk("t2_w_last", axi.w_last, (i == 3));
      end
      if (i == 0) chk("t2_aw_len", axi.aw_len, 3);
      chk("t2_gnt", wr_gnt, (i == 6));
      if (axi.aw_valid && axi.aw_ready) aw_hs++;
    end
    nxt(); wr_req = 0; axi.aw_ready = 0; axi.w_ready = 0; #1;
    chk("t2_aw_count", aw_hs, 1);
    chk("t2_wr_out", wr_out, 1);
    chk("t2_aw_idle", axi.aw_valid, 0);

    // T3: AW accepted first, W toggling -> WR_DATA, grant on 4th W handshake
    for (int i = 0; i < 7; i++) begin
      nxt(); wr_req = 1; wr_blen = 3; axi.aw_ready = (i == 0); axi.w_ready = (i % 2 == 0); #1;
      chk("t3_aw_valid", axi.aw_valid, (i == 0));
      chk("t3_w_valid", axi.w_valid, 1);
      chk("t3_w_data", axi.w_data, 32'hA0 + (i + 1) / 2);
      chk("t3_w_last", axi.w_last, ((i + 1) / 2 == 3));
      chk("t3_gnt", wr_gnt, (i == 6));
    end
    nxt(); wr_req = 0; axi.aw_ready = 0; axi.w_ready = 0; #1;
    chk("t3_wr_out", wr_out, 2);

    // T4: counter full -> third write throttled until a B returns
    for (int i = 0; i < 8; i++) begin
      nxt(); wr_req = (i < 4); wr_blen = 0; axi.aw_ready = 1; axi.w_ready = 1;
      axi.b_valid = (i >= 2 && i <= 3) || (i >= 5 && i <= 6); wr_rdy = 1; #1;
      case (i)
        0, 1, 2: begin
          chk("t4_aw_blocked", axi.aw_valid, 0);
          chk("t4_gnt_blocked", wr_gnt, 0);
          chk("t4_wr_out_full", wr_out, 2);
        end
        3: begin
          chk("t4_aw_valid", axi.aw_valid, 1);
          chk("t4_gnt", wr_gnt, 1);
          chk("t4_wr_out_1", wr_out, 1);
        end
        4: chk("t4_inc_dec_same", wr_out, 1);
        5: chk("t4_wr_out_pre_b", wr_out, 1);
        default: chk("t4_no_underflow", wr_out, 0);
      endcase
    end
    nxt(); axi.b_valid = 0; wr_rdy = 0; axi.aw_ready = 0; axi.w_ready = 0;

    // T5: MaxOutstandingRd=1 -> second read held until last R handshake
    for (int i = 0; i < 7; i++) begin
      nxt(); rd_req = (i < 5); axi.ar_ready = 1; rd_rdy = 1;
      axi.r_valid = (i >= 2 && i <= 3) || (i == 5); axi.r_last = (i == 3) || (i == 5);
      axi.r_data = 32'h55 + i; axi.r_resp = 2'b01; axi.r_id = 4'd5; #1;
      case (i)
        0: begin
          chk("t5_ar_valid", axi.ar_valid, 1);
          chk("t5_rd_gnt", rd_gnt, 1);
          chk("t5_ar_len", axi.ar_len, 1);
          chk("t5_rd_out0", rd_out, 0);
        end
        1: begin
          chk("t5_ar_blocked", axi.ar_valid, 0);
          chk("t5_rd_out1", rd_out, 1);
        end
        2: begin
          chk("t5_r_valid", rd_valid, 1);
          chk("t5_r_data", rd_data, 32'h57);
          chk("t5_r_last", rd_last, 0);
          chk("t5_r_exokay", rd_exokay, 1);
          chk("t5_ar_blocked2", axi.ar_valid, 0);
        end
        3: begin
          chk("t5_nonlast_keeps", rd_out, 1);
          chk("t5_ar_blocked3", axi.ar_valid, 0);
        end
        4: begin
          chk("t5_rd_out_freed", rd_out, 0);
          chk("t5_rd_gnt2", rd_gnt, 1);
        end
        5: chk("t5_rd_out2", rd_out, 1);
        default: chk("t5_rd_out_end", rd_out, 0);
      endcase
    end
    nxt(); axi.r_valid = 0; axi.r_last = 0; rd_rdy = 0; axi.ar_ready = 0;

    // T6: reset in the middle of a burst (wcnt=2)
    nxt(); wr_req = 1; wr_blen = 0; axi.aw_ready = 1; axi.w_ready = 1; #1;
    chk("t6_pre_gnt", wr_gnt, 1);
    for (int i = 0; i < 3; i++) begin
      nxt(); wr_req = 1; wr_blen = 3; axi.aw_ready = 0; axi.w_ready = 1; #1;
      chk("t6_w_data", axi.w_data, 32'hA0 + i);
    end
    rst_n = 1'b0; wr_req = 0; #1;
    chk("t6_rst_wr_out", wr_out, 0);
    chk("t6_rst_w_valid", axi.w_valid, 0);
    nxt(); rst_n = 1'b1; #1;
    chk("t6_aw_valid", axi.aw_valid, 0);
    chk("t6_w_valid", axi.w_valid, 0);
    chk("t6_gnt", wr_gnt, 0);
    chk("t6_rd_out", rd_out, 0);
    nxt(); wr_req = 1; wr_blen = 0; axi.aw_ready = 1; axi.w_ready = 1; #1;
    chk("t6_wcnt_cleared", axi.w_data, 32'hA0);
    chk("t6_regrant", wr_gnt, 1);

    // atomics with R response consume a read slot
    nxt(); wr_atop = 6'h20; #1;
    chk("atop_field", axi.aw_atop, 6'h20);
    chk("atop_gnt", wr_gnt, 1);
    nxt(); wr_req = 0; axi.b_valid = 1; wr_rdy = 1; #1;
    chk("atop_rd_out", rd_out, 1);
    chk("atop_wr_out", wr_out, 2);
    nxt(); #1;
    nxt(); axi.b_valid = 0; wr_req = 1; #1;
    chk("atop_wr_drained", wr_out, 0);
    chk("atop_rd_throttle", axi.aw_valid, 0);
    nxt(); wr_atop = 6'h00; #1;
    chk("plain_after_atop", wr_gnt, 1);
    nxt(); wr_req = 0; wr_rdy = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
